axi4lite_transactor: RTL and testbench
======================================

// Module: axi4lite_transactor
// PURPOSE
// AXI4-Lite store-and-forward bridge with one clock domain.
// Accepts transactions on an upstream AXI4-Lite slave port (axi4_Lite.axiSlave modport).
// Re-issues each transaction on a flat downstream master port (signals suffixed M).
// Returns the downstream response upstream. Write and read paths are independent; each holds one outstanding transaction.
// PARAMETERS
// addrWidth  32  address width, both sides
// dataWidth  32  data width, both sides; strobe width = dataWidth/8
// PORTS
// clk       in   1            clock; all logic on rising edge
// rst       in   1            synchronous reset, active-high
// i_f       ifc  -            axi4_Lite.axiSlave; DUT drives awready, wready, bvalid, bresp[1:0], arready, rvalid, rdata, rresp[1:0]
//                             master drives awvalid, awaddr, awprot[2:0], wvalid, wdata, wstrb, bready, arvalid, araddr, arprot[2:0], rready
// awreadyM  in   1            downstream AW ready
// wreadyM   in   1            downstream W ready
// arreadyM  in   1            downstream AR ready
// bvalidM   in   1            downstream B valid
// rvalidM   in   1            downstream R valid
// brespM    in   2            downstream write response
// rdataM    in   dataWidth    downstream read data
// rrespM    in   2            downstream read response
// awaddrM   out  addrWidth    downstream write address
// awprotM   out  3            downstream write protection
// wdataM    out  dataWidth    downstream write data
// wstrbM    out  dataWidth/8  downstream write strobes
// araddrM   out  addrWidth    downstream read address
// arprotM   out  3            downstream read protection
// awvalidM  out  1            downstream AW valid (appended after arprotM)
// wvalidM   out  1            downstream W valid
// arvalidM  out  1            downstream AR valid
// breadyM   out  1            downstream B ready
// rreadyM   out  1            downstream R ready
// BEHAVIOUR
// - Handshake: a transfer completes in a cycle where valid & ready are both high at the clk edge.
// - All outputs are registers. Reset values: every valid/ready = 0; every data/addr/prot/strb/resp = 0.
// - Write FSM, one state per step:
//   - W_IDLE: awready=1. On awvalid, latch awaddr/awprot -> W_AW.
//   - W_AW: awvalidM=1. On awreadyM -> W_WD.
//   - W_WD: wready=1. On wvalid, latch wdata/wstrb -> W_W.
//   - W_W: wvalidM=1. On wreadyM -> W_B.
//   - W_B: breadyM=1. On bvalidM, latch brespM -> W_BR.
//   - W_BR: bvalid=1, bresp = latched value. On bready -> W_IDLE.
// - Read FSM, one state per step:
//   - R_IDLE: arready=1. On arvalid, latch araddr/arprot -> R_AR.
//   - R_AR: arvalidM=1. On arreadyM -> R_RW.
//   - R_RW: rreadyM=1. On rvalidM, latch rdataM/rrespM -> R_R.
//   - R_R: rvalid=1, rdata/rresp = latched values. On rready -> R_IDLE.
// - Latency: each hop adds exactly 1 cycle. Example: an upstream AW handshake at edge N raises awvalidM from edge N+1.
// - Each valid/ready deasserts on the edge after its handshake. A valid is held until its handshake (AXI rule); no timeout.
// - wvalid arriving before the AW forward completes is not accepted: wready stays 0 until W_WD, and the master holds W.
// - Payload pass-through: addr, prot, strb and resp pass unchanged, including SLVERR/DECERR. Data is never modified.
// - Next transaction: awready/arready return to 1 one cycle after the B/R handshake.
// - Write and read FSMs advance concurrently with no mutual ordering.
// - Reset mid-operation: both FSMs return to IDLE and all outputs take reset values. In-flight transactions are dropped silently.
// - awready/arready rise on the first edge with rst=0.
// TESTING
// - Write, ready downstream: awaddr=0x100, wdata=0xA5A5_0001, wstrb=0xF, brespM=0.
//   -> awaddrM=0x100, wdataM=0xA5A5_0001, wstrbM=0xF; bvalid with bresp=0.
// - Write with awreadyM delayed 7 cycles: awvalidM/awaddrM stable throughout; wready stays 0 until the cycle after awreadyM.
// - Read: araddr=0x3FC, rdataM=0x0000_0123, rrespM=2 -> rvalid with rdata=0x123, rresp=2.
//   Hold rready=0 5 cycles: rvalid/rdata stay stable.
// - Concurrency: a write and a read issued in the same cycle both complete with correct payloads.
//   Ten back-to-back writes with random ready gaps (0-15 cycles) all complete in order.
// - Reset asserted while in W_W: next cycle wvalidM=0, bvalid=0; awready=1 after rst drops.

Source files
------------

// File: rtl/axi4lite_transactor_if.sv
// AXI4-Lite upstream bundle for the store-and-forward bridge.
// The master side drives valids/payloads; the slave side drives readies/responses.
interface axi4_Lite #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [addrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   wvalid;
  logic                   wready;
  logic [dataWidth-1:0]   wdata;
  logic [dataWidth/8-1:0] wstrb;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  logic                   arvalid;
  logic                   arready;
  logic [addrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   rvalid;
  logic                   rready;
  logic [dataWidth-1:0]   rdata;
  logic [1:0]             rresp;

  modport axiSlave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

  modport axiMaster (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_transactor.sv
// AXI4-Lite store-and-forward bridge: upstream slave port re-issued on a
// flat downstream master port, one outstanding write and one read.
module axi4lite_transactor #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axi4_Lite.axiSlave             i_f,
  input  logic                   awreadyM,
  input  logic                   wreadyM,
  input  logic                   arreadyM,
  input  logic                   bvalidM,
  input  logic                   rvalidM,
  input  logic [1:0]             brespM,
  input  logic [dataWidth-1:0]   rdataM,
  input  logic [1:0]             rrespM,
  output logic [addrWidth-1:0]   awaddrM,
  output logic [2:0]             awprotM,
  output logic [dataWidth-1:0]   wdataM,
  output logic [dataWidth/8-1:0] wstrbM,
  output logic [addrWidth-1:0]   araddrM,
  output logic [2:0]             arprotM,
  output logic                   awvalidM,
  output logic                   wvalidM,
  output logic                   arvalidM,
  output logic                   breadyM,
  output logic                   rreadyM
);

  typedef enum logic [2:0] {
    W_IDLE, W_AW, W_WD, W_W, W_B, W_BR
  } wState_t;

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_RW, R_R
  } rState_t;

  wState_t wState, wNext;
  rState_t rState, rNext;

  logic                 awreadyQ, wreadyQ, bvalidQ;
  logic                 arreadyQ, rvalidQ;
  logic [1:0]           brespQ, rrespQ;
  logic [dataWidth-1:0] rdataQ;

  logic awHs, wHs, bHsM, arHs, rHsM;

  // Upstream handshakes use the registered readies, so the first cycle
  // out of reset (IDLE state, ready still low) cannot accept anything.
  assign awHs = i_f.awvalid & awreadyQ;
  assign wHs  = i_f.wvalid & wreadyQ;
  assign bHsM = bvalidM & breadyM;
  assign arHs = i_f.arvalid & arreadyQ;
  assign rHsM = rvalidM & rreadyM;

  always_comb begin
    wNext = wState;
    unique case (wState)
      W_IDLE:  if (awHs) wNext = W_AW;
      W_AW:    if (awreadyM) wNext = W_WD;
      W_WD:    if (wHs) wNext = W_W;
      W_W:     if (wreadyM) wNext = W_B;
      W_B:     if (bvalidM) wNext = W_BR;
      W_BR:    if (i_f.bready) wNext = W_IDLE;
      default: wNext = W_IDLE;
    endcase
  end

  always_comb begin
    rNext = rState;
    unique case (rState)
      R_IDLE:  if (arHs) rNext = R_AR;
      R_AR:    if (arreadyM) rNext = R_RW;
      R_RW:    if (rvalidM) rNext = R_R;
      R_R:     if (i_f.rready) rNext = R_IDLE;
      default: rNext = R_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wState   <= W_IDLE;
      awreadyQ <= 1'b0;
      awvalidM <= 1'b0;
      wreadyQ  <= 1'b0;
      wvalidM  <= 1'b0;
      breadyM  <= 1'b0;
      bvalidQ  <= 1'b0;
      awaddrM  <= '0;
      awprotM  <= '0;
      wdataM   <= '0;
      wstrbM   <= '0;
      brespQ   <= '0;
    end else begin
      wState   <= wNext;
      awreadyQ <= (wNext == W_IDLE);
      awvalidM <= (wNext == W_AW);
      wreadyQ  <= (wNext == W_WD);
      wvalidM  <= (wNext == W_W);
      breadyM  <= (wNext == W_B);
      bvalidQ  <= (wNext == W_BR);
      if (awHs) begin
        awaddrM <= i_f.awaddr;
        awprotM <= i_f.awprot;
      end
      if (wHs) begin
        wdataM <= i_f.wdata;
        wstrbM <= i_f.wstrb;
      end
      if (bHsM) brespQ <= brespM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rState   <= R_IDLE;
      arreadyQ <= 1'b0;
      arvalidM <= 1'b0;
      rreadyM  <= 1'b0;
      rvalidQ  <= 1'b0;
      araddrM  <= '0;
      arprotM  <= '0;
      rdataQ   <= '0;
      rrespQ   <= '0;
    end else begin
      rState   <= rNext;
      arreadyQ <= (rNext == R_IDLE);
      arvalidM <= (rNext == R_AR);
      rreadyM  <= (rNext == R_RW);
      rvalidQ  <= (rNext == R_R);
      if (arHs) begin
        araddrM <= i_f.araddr;
        arprotM <= i_f.arprot;
      end
      if (rHsM) begin
        rdataQ <= rdataM;
        rrespQ <= rrespM;
      end
    end
  end

  assign i_f.awready = awreadyQ;
  assign i_f.wready  = wreadyQ;
  assign i_f.bvalid  = bvalidQ;
  assign i_f.bresp   = brespQ;
  assign i_f.arready = arreadyQ;
  assign i_f.rvalid  = rvalidQ;
  assign i_f.rdata   = rdataQ;
  assign i_f.rresp   = rrespQ;

endmodule

// File: tb/tb_axi4lite_transactor.sv
// Directed bench for axi4lite_transactor: upstream master and downstream
// slave tasks, run serially or forked for the concurrent cases.
module tb_axi4lite_transactor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awreadyM = 1'b0;
  logic        wreadyM = 1'b0;
  logic        arreadyM = 1'b0;
  logic        bvalidM = 1'b0;
  logic        rvalidM = 1'b0;
  logic [1:0]  brespM = '0;
  logic [31:0] rdataM = '0;
  logic [1:0]  rrespM = '0;
  logic [31:0] awaddrM, wdataM, araddrM;
  logic [2:0]  awprotM, arprotM;
  logic [3:0]  wstrbM;
  logic        awvalidM, wvalidM, arvalidM, breadyM, rreadyM;

  int compared = 0;
  int mismatched = 0;

  axi4_Lite #(.addrWidth(32), .dataWidth(32)) i_f ();

  axi4lite_transactor #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rst(rst), .i_f(i_f),
    .awreadyM(awreadyM), .wreadyM(wreadyM), .arreadyM(arreadyM),
    .bvalidM(bvalidM), .rvalidM(rvalidM), .brespM(brespM),
    .rdataM(rdataM), .rrespM(rrespM),
    .awaddrM(awaddrM), .awprotM(awprotM), .wdataM(wdataM),
    .wstrbM(wstrbM), .araddrM(araddrM), .arprotM(arprotM),
    .awvalidM(awvalidM), .wvalidM(wvalidM), .arvalidM(arvalidM),
    .breadyM(breadyM), .rreadyM(rreadyM)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int k);
    case (k)
      0: return awvalidM;
      1: return wvalidM;
      2: return breadyM;
      3: return arvalidM;
      4: return rreadyM;
      5: return i_f.awready;
      6: return i_f.wready;
      7: return i_f.bvalid;
      8: return i_f.arready;
      default: return i_f.rvalid;
    endcase
  endfunction

  task automatic waitSig(input int k, input string tag);
    for (int n = 0; n < 200; n++) begin
      if (sig(k)) break;
      tick();
    end
    chk(tag, 64'(sig(k)), 64'd1);
  endtask

  task automatic wrMaster(input logic [31:0] addr, input logic [2:0] prot,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] expResp);
    i_f.awvalid = 1'b1;
    i_f.awaddr  = addr;
    i_f.awprot  = prot;
    i_f.wvalid  = 1'b1;
    i_f.wdata   = data;
    i_f.wstrb   = strb;
    waitSig(5, "awready");
    tick();
    i_f.awvalid = 1'b0;
    waitSig(6, "wready");
    tick();
    i_f.wvalid = 1'b0;
    waitSig(7, "bvalid");
    chk("bresp", 64'(i_f.bresp), 64'(expResp));
    i_f.bready = 1'b1;
    tick();
    i_f.bready = 1'b0;
    chk("bvalid_drop", 64'(i_f.bvalid), 64'd0);
    chk("awready_back", 64'(i_f.awready), 64'd1);
  endtask

  task automatic wrSlave(input int awDly, input int wDly, input int bDly,
                         input logic [1:0] resp, input logic [31:0] expAddr,
                         input logic [2:0] expProt, input logic [31:0] expData,
                         input logic [3:0] expStrb);
    waitSig(0, "awvalidM");
    for (int i = 0; i < awDly; i++) begin
      chk("awvalidM_hold", 64'(awvalidM), 64'd1);
      chk("awaddrM_hold", 64'(awaddrM), 64'(expAddr));
      chk("wready_early", 64'(i_f.wready), 64'd0);
      tick();
    end
    chk("awaddrM", 64'(awaddrM), 64'(expAddr));
    chk("awprotM", 64'(awprotM), 64'(expProt));
    awreadyM = 1'b1;
    tick();
    awreadyM = 1'b0;
    chk("awvalidM_drop", 64'(awvalidM), 64'd0);
    waitSig(1, "wvalidM");
    repeat (wDly) tick();
    chk("wdataM", 64'(wdataM), 64'(expData));
    chk("wstrbM", 64'(wstrbM), 64'(expStrb));
    wreadyM = 1'b1;
    tick();
    wreadyM = 1'b0;
    waitSig(2, "breadyM");
    repeat (bDly) tick();
    bvalidM = 1'b1;
    brespM  = resp;
    tick();
    bvalidM = 1'b0;
    brespM  = 2'd0;
  endtask

  task automatic rdMaster(input logic [31:0] addr, input logic [2:0] prot,
                          input logic [31:0] expData, input logic [1:0] expResp,
                          input int hold);
    i_f.arvalid = 1'b1;
    i_f.araddr  = addr;
    i_f.arprot  = prot;
    waitSig(8, "arready");
    tick();
    i_f.arvalid = 1'b0;
    waitSig(9, "rvalid");
    for (int i = 0; i < hold; i++) begin
      chk("rvalid_hold", 64'(i_f.rvalid), 64'd1);
      chk("rdata_hold", 64'(i_f.rdata), 64'(expData));
      tick();
    end
    chk("rdata", 64'(i_f.rdata), 64'(expData));
    chk("rresp", 64'(i_f.rresp), 64'(expResp));
    i_f.rready = 1'b1;
    tick();
    i_f.rready = 1'b0;
    chk("rvalid_drop", 64'(i_f.rvalid), 64'd0);
    chk("arready_back", 64'(i_f.arready), 64'd1);
  endtask

  task automatic rdSlave(input int arDly, input int rDly,
                         input logic [31:0] data, input logic [1:0] resp,
                         input logic [31:0] expAddr, input logic [2:0] expProt);
    waitSig(3, "arvalidM");
    repeat (arDly) tick();
    chk("araddrM", 64'(araddrM), 64'(expAddr));
    chk("arprotM", 64'(arprotM), 64'(expProt));
    arreadyM = 1'b1;
    tick();
    arreadyM = 1'b0;
    waitSig(4, "rreadyM");
    repeat (rDly) tick();
    rvalidM = 1'b1;
    rdataM  = data;
    rrespM  = resp;
    tick();
    rvalidM = 1'b0;
    rdataM  = '0;
    rrespM  = '0;
  endtask

  initial begin
    logic [31:0] d;
    i_f.awvalid = 1'b0; i_f.awaddr = '0; i_f.awprot = '0;
    i_f.wvalid  = 1'b0; i_f.wdata  = '0; i_f.wstrb  = '0;
    i_f.bready  = 1'b0;
    i_f.arvalid = 1'b0; i_f.araddr = '0; i_f.arprot = '0;
    i_f.rready  = 1'b0;

    repeat (3) tick();
    chk("rst_awready", 64'(i_f.awready), 64'd0);
    chk("rst_arready", 64'(i_f.arready), 64'd0);
    chk("rst_awvalidM", 64'(awvalidM), 64'd0);
    chk("rst_bvalid", 64'(i_f.bvalid), 64'd0);
    chk("rst_awaddrM", 64'(awaddrM), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_awready", 64'(i_f.awready), 64'd1);
    chk("post_rst_arready", 64'(i_f.arready), 64'd1);

    // basic write, downstream ready immediately
    fork
      wrMaster(32'h100, 3'd0, 32'hA5A5_0001, 4'hF, 2'd0);
      wrSlave(0, 0, 0, 2'd0, 32'h100, 3'd0, 32'hA5A5_0001, 4'hF);
    join

    // awreadyM held off for 7 cycles
    fork
      wrMaster(32'h204, 3'd5, 32'h1234_5678, 4'h3, 2'd0);
      wrSlave(7, 1, 2, 2'd0, 32'h204, 3'd5, 32'h1234_5678, 4'h3);
    join

    // read with SLVERR and a 5-cycle rready stall
    fork
      rdMaster(32'h3FC, 3'd2, 32'h0000_0123, 2'd2, 5);
      rdSlave(0, 0, 32'h0000_0123, 2'd2, 32'h3FC, 3'd2);
    join

    // write and read issued together
    fork
      wrMaster(32'h0800, 3'd1, 32'hDEAD_BEEF, 4'h9, 2'd3);
      wrSlave(2, 0, 3, 2'd3, 32'h0800, 3'd1, 32'hDEAD_BEEF, 4'h9);
      rdMaster(32'h0C00, 3'd7, 32'hCAFE_F00D, 2'd0, 1);
      rdSlave(1, 4, 32'hCAFE_F00D, 2'd0, 32'h0C00, 3'd7);
    join

    // ten back-to-back writes with random downstream gaps
    for (int i = 0; i < 10; i++) begin
      int g0, g1, g2;
      g0 = int'($urandom_range(15, 0));
      g1 = int'($urandom_range(15, 0));
      g2 = int'($urandom_range(15, 0));
      d = 32'h5000_0000 + 32'(i * 17);
      fork
        wrMaster(32'(i * 4), 3'(i), d, 4'(i + 1), 2'(i));
        wrSlave(g0, g1, g2, 2'(i), 32'(i * 4), 3'(i), d, 4'(i + 1));
      join
    end

    // reset while the write sits in W_W
    awreadyM = 1'b1;
    i_f.awvalid = 1'b1; i_f.awaddr = 32'h44; i_f.awprot = 3'd0;
    i_f.wvalid  = 1'b1; i_f.wdata = 32'h77; i_f.wstrb = 4'hF;
    waitSig(1, "wvalidM_pre_rst");
    i_f.awvalid = 1'b0;
    i_f.wvalid  = 1'b0;
    awreadyM = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_wvalidM", 64'(wvalidM), 64'd0);
    chk("rst_mid_bvalid", 64'(i_f.bvalid), 64'd0);
    chk("rst_mid_wdataM", 64'(wdataM), 64'd0);
    chk("rst_mid_awready", 64'(i_f.awready), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_mid_awready_back", 64'(i_f.awready), 64'd1);
    tick();
    chk("rst_mid_idle_wvalidM", 64'(wvalidM), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
